// File: rtl/clock_domain_pkg.sv
// Shared definitions for the toggle req/ack clock-domain crossing.
// Holds the synchroniser minimum and the FIFO level-width helper.
package clock_domain_pkg;

  localparam int SYNC_STAGES_MIN = 2;

  function automatic int level_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/clock_domain_sync.sv
// N-flop synchroniser for a single-bit level/toggle signal.
// Reused by both the import and export sides of the crossing.
module clock_domain_sync
  import clock_domain_pkg::*;
#(
  parameter int STAGES = SYNC_STAGES_MIN
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk) begin
    if (rst) ff <= '0;
    else     ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/clock_domain_import_fifo.sv
// Destination half of the toggle req/ack crossing with a local FIFO.
// Optional parity check: define CLOCK_DOMAIN_IMPORT_FIFO_PARITY_EN.
module clock_domain_import_fifo
  import clock_domain_pkg::*;
#(
  parameter int SIZE        = 8,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [SIZE-1:0]             handshake_data,
  input  logic                        handshake_parity,
  input  logic                        handshake_req,
  output logic                        handshake_ack,
  output logic [SIZE-1:0]             data,
  output logic                        valid,
  input  logic                        ready,
  output logic [level_w(DEPTH)-1:0]   level,
  output logic                        err
);

  localparam int LW = level_w(DEPTH);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // DEPTH=1 keeps both pointers pinned at 0
  localparam logic [PW-1:0] PTR_STEP =
    (DEPTH > 1) ? PW'(1) : '0;

`ifdef CLOCK_DOMAIN_IMPORT_FIFO_PARITY_EN
  localparam int EW = SIZE + 1;
`else
  localparam int EW = SIZE;
`endif

  logic          req_s;
  logic          pending;
  logic          pop;
  logic          space;
  logic          capture;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [EW-1:0] wr_word;
  logic [EW-1:0] head;
  logic [EW-1:0] mem [DEPTH];

  clock_domain_sync #(
    .STAGES (SYNC_STAGES)
  ) u_req_sync (
    .clk (clk),
    .rst (rst),
    .d   (handshake_req),
    .q   (req_s)
  );

  assign pending = req_s != handshake_ack;
  assign valid   = level != '0;
  assign pop     = valid && ready;
  assign space   = (level < LW'(DEPTH)) || pop;
  assign capture = pending && space;
  assign head    = mem[rd_ptr];

`ifdef CLOCK_DOMAIN_IMPORT_FIFO_PARITY_EN
  assign wr_word = {^handshake_data ^ handshake_parity,
                    handshake_data};
  assign data    = head[SIZE-1:0];
  assign err     = valid && head[SIZE];
`else
  logic unused_parity;
  assign unused_parity = handshake_parity;
  assign wr_word       = handshake_data;
  assign data          = head;
  assign err           = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      level         <= '0;
      handshake_ack <= 1'b0;
    end else begin
      if (capture) begin
        wr_ptr        <= wr_ptr + PTR_STEP;
        handshake_ack <= req_s;
      end
      if (pop) rd_ptr <= rd_ptr + PTR_STEP;
      if (capture && !pop)
        level <= level + LW'(1);
      else if (pop && !capture)
        level <= level - LW'(1);
    end
  end

  // Storage needs no reset; level qualifies every entry
  always_ff @(posedge clk) begin
    if (!rst && capture) mem[wr_ptr] <= wr_word;
  end

endmodule

// File: doc/clock_domain_import_fifo.md
Name: clock_domain_import_fifo

Overview:
Destination-side half of the toggle req/ack clock-domain crossing. Each word is transferred by toggling `handshake_req`. The block synchronises the request through a configurable-depth synchroniser, stores each received word in a local DEPTH-entry FIFO, and presents it on a valid/ready stream. It withholds `handshake_ack` while the FIFO is full, so backpressure propagates to the source clock domain without losing data.

Parameters:
- SIZE, 8, data word width in bits.
- DEPTH, 4, number of FIFO entries; must be a power of 2 and at least 1.
- SYNC_STAGES, 2, flip-flops in the `handshake_req` synchroniser; must be at least 2.

Ports:
- clk  in  1  destination clock; all logic runs on its rising edge.
- rst  in  1  synchronous, active-high reset.
- handshake_data  in  SIZE  word from the source domain; held stable while req != ack.
- handshake_parity  in  1  even-parity bit over handshake_data; used only with the optional feature.
- handshake_req  in  1  toggle request from the source domain (asynchronous to clk).
- handshake_ack  out  1  toggle acknowledge to the source domain; registered.
- data  out  SIZE  head-of-FIFO word (first-word-fall-through).
- valid  out  1  data holds a word.
- ready  in  1  consumer accepts data on this cycle when valid is also high.
- level  out  $clog2(DEPTH+1)  number of words currently stored.
- err  out  1  parity-error flag for the head word; constant 0 without the optional feature.

Behaviour:
- Interface decision: one clock (clk); reset is synchronous and active-high (rst).
- Reset values:
  - synchroniser flops 0, handshake_ack 0, read/write pointers 0, level 0.
  - valid 0, err 0; data is don't-care.
- Synchroniser: req_s is the output of the SYNC_STAGES-deep shift register clocked from handshake_req.
- pending = (req_s != handshake_ack).
- pop = valid && ready. Pop advances the read pointer and decrements level.
- space = (level < DEPTH) || pop. A pop in the same cycle frees the slot, so a full FIFO with ready high still accepts.
- capture = pending && space. On capture:
  - mem[wr_ptr] <= handshake_data;
  - wr_ptr increments, wrapping modulo DEPTH;
  - handshake_ack <= req_s.
- handshake_ack changes only on capture; exactly one capture per req toggle.
- Pending while full: the FIFO holds, ack is withheld, and nothing is dropped. Capture happens on the first cycle with space.
- Capture and pop on the same cycle: level is unchanged and both pointers advance.
- Latency from a req toggle (FIFO not full):
  - ack toggles SYNC_STAGES+1 clk edges later;
  - valid rises on the same edge as ack when the FIFO was empty.
- valid = (level != 0); data = mem[rd_ptr] (combinational read of registered storage).
- Throughput: at most one word per full handshake round trip; the FIFO absorbs consumer stalls only.
- Pointers are $clog2(DEPTH) bits wide and wrap naturally. With DEPTH=1 they are 1 bit wide and held at 0.
- Reset mid-operation:
  - all stored words are discarded and ack returns to 0;
  - if req is 1 after reset, one new capture of the current handshake_data follows;
  - the source domain must be reset together with this block to avoid that capture.
- No combinational path from handshake_req to any output.

Optional Feature:
- Macro: CLOCK_DOMAIN_IMPORT_FIFO_PARITY_EN.
- Defined:
  - each FIFO entry stores SIZE+1 bits, the extra bit being bad = ^handshake_data ^ handshake_parity;
  - err = bad bit of the head entry, qualified by valid;
  - bad words are still acked and delivered, never dropped.
- Undefined: handshake_parity is ignored, entries are SIZE bits wide, err is tied to 0.

Decomposition:
- Package clock_domain_pkg:
  - localparam SYNC_STAGES_MIN = 2;
  - helper function for the level width ($clog2(DEPTH+1)).
- Sub-module clock_domain_sync (parameter STAGES, ports clk, rst, d, q). It is the reusable N-flop synchroniser and is shared with the future export side.

Test Plan:
1. Basic transfer: after reset, SIZE=8, DEPTH=4, SYNC_STAGES=2; set handshake_data=0xA5, toggle req 0→1, ready=1 → ack=1 exactly 3 clk edges later; valid pulses for 1 cycle with data=0xA5; level returns to 0.
2. Fill and backpressure: ready=0; source performs 5 handshakes 0x01..0x05 → the first 4 are acked, level=4, ack stays 0 with req=1 for the 5th.
   - Raise ready for 1 cycle → 0x01 is popped, 0x05 is captured on the same edge, level stays 4, ack→1.
   - Drain → output order is 0x02,0x03,0x04,0x05.
3. Same-cycle capture and pop at level=1 → level stays 1; no word is lost or duplicated across 16 transfers with random ready.
4. Reset mid-operation: level=3 and pending req; assert rst for 1 cycle with the source also reset (req=0) → valid=0, level=0, ack=0, and no capture afterwards.
5. Pointer wrap: 37 transfers of an incrementing pattern with random ready, DEPTH=4 → output sequence is exactly 0..36 in order.
6. CLOCK_DOMAIN_IMPORT_FIFO_PARITY_EN defined:
   - send 0x03 with parity=1 → delivered, err=1 while it is head;
   - send 0x03 with parity=0 → err=0.
